// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - request/response bundle of the parameterised synchronous FIFO
interface param_fifo_if #(
   parameter int DATA_SIZE      = 8,
   parameter int ADDR_SPACE_EXP = 4
);
   logic                      write_to_fifo;
   logic                      read_from_fifo;
   logic [DATA_SIZE-1:0]      write_data_in;
   logic                      clear_errors;
   logic [DATA_SIZE-1:0]      read_data_out;
   logic [ADDR_SPACE_EXP:0]   count;
   logic                      empty;
   logic                      full;
   logic                      almost_empty;
   logic                      almost_full;
   logic                      overflow;
   logic                      underflow;

   // Producer/consumer side that issues requests and observes status
   modport master (
      output write_to_fifo, read_from_fifo, write_data_in, clear_errors,
      input  read_data_out, count, empty, full, almost_empty, almost_full,
             overflow, underflow
   );

   // FIFO side
   modport slave (
      input  write_to_fifo, read_from_fifo, write_data_in, clear_errors,
      output read_data_out, count, empty, full, almost_empty, almost_full,
             overflow, underflow
   );
endinterface

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - first-word-fall-through FIFO with occupancy flags and sticky error flags
module param_fifo #(
   parameter int DATA_SIZE        = 8,
   parameter int ADDR_SPACE_EXP   = 4,
   parameter int ALMOST_FULL_LVL  = 12,
   parameter int ALMOST_EMPTY_LVL = 2
) (
   input  logic       clk,
   input  logic       reset,
   param_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_SPACE_EXP;
   localparam int CNT_W = ADDR_SPACE_EXP + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_LVL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_LVL);

   logic [DATA_SIZE-1:0]      mem_q [DEPTH];
   logic [ADDR_SPACE_EXP-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SPACE_EXP-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      overflow_q, overflow_d;
   logic                      underflow_q, underflow_d;
   logic                      wr_accept;
   logic                      rd_accept;

   // Accept decisions and next-state; a full FIFO still takes a write when a read frees a slot in the same edge
   always_comb begin
      rd_accept   = bus.read_from_fifo && (count_q != '0);
      wr_accept   = bus.write_to_fifo && ((count_q != DEPTH_C) || bus.read_from_fifo);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A fresh error outranks a clear arriving in the same cycle
      overflow_d  = (overflow_q && !bus.clear_errors) ||
                    (bus.write_to_fifo && !wr_accept);
      underflow_d = (underflow_q && !bus.clear_errors) ||
                    (bus.read_from_fifo && !rd_accept);
   end

   // Pointer, occupancy and error-flag registers; reset empties the queue immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents survive reset since the pointers alone define validity
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= bus.write_data_in;
      end
   end

   assign bus.read_data_out = mem_q[rd_ptr_q];
   assign bus.count         = count_q;
   assign bus.empty         = (count_q == '0);
   assign bus.full          = (count_q == DEPTH_C);
   assign bus.almost_full   = (count_q >= AF_C);
   assign bus.almost_empty  = (count_q <= AE_C);
   assign bus.overflow      = overflow_q;
   assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard bench for param_fifo
module tb_param_fifo;
   logic clk;
   logic reset;

   int errors = 0;
   int checks = 0;
   logic [7:0] model_q[$];

   param_fifo_if #(.DATA_SIZE(8), .ADDR_SPACE_EXP(4)) bus ();

   param_fifo #(
      .DATA_SIZE(8), .ADDR_SPACE_EXP(4), .ALMOST_FULL_LVL(12), .ALMOST_EMPTY_LVL(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock of stimulus; read data is popped from the scoreboard and compared before the edge
   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic clr);
      logic       wa, ra;
      logic [7:0] exp_d;
      bus.write_to_fifo  = w;
      bus.read_from_fifo = r;
      bus.write_data_in  = d;
      bus.clear_errors   = clr;
      ra = r && (model_q.size() > 0);
      wa = w && ((model_q.size() < 16) || r);
      if (ra) begin
         exp_d = model_q.pop_front();
         checks++;
         if (bus.read_data_out !== exp_d) begin
            errors++;
            $display("FAIL rd_data: got %h expected %h", bus.read_data_out, exp_d);
         end
      end
      if (wa) model_q.push_back(d);
      @(posedge clk);
      #1;
      bus.write_to_fifo  = 1'b0;
      bus.read_from_fifo = 1'b0;
      bus.clear_errors   = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", bus.empty); end
      checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b expected 1", bus.almost_empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", bus.full); end
      checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b expected 0", bus.almost_full); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
      checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL rst_unf: got %b expected 0", bus.underflow); end
   endtask

   task automatic test_basic();
      step(1, 0, 8'h11, 0);
      step(1, 0, 8'h22, 0);
      step(1, 0, 8'h33, 0);
      checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", bus.count); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", bus.empty); end
      checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL basic_aempty: got %b expected 0", bus.almost_empty); end
      for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_drained: got %b expected 1", bus.empty); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 8'h40 + 8'(i), 0);
         if (i == 10) begin
            checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL afull_11: got %b expected 0", bus.almost_full); end
         end
         if (i == 11) begin
            checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL afull_12: got %b expected 1", bus.almost_full); end
         end
         if (i == 14) begin
            checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_15: got %b expected 0", bus.full); end
         end
      end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_16: got %b expected 1", bus.full); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", bus.overflow); end
      step(1, 0, 8'hEE, 0);
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
      checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", bus.count); end
   endtask

   task automatic test_full_rw();
      step(0, 0, 8'h00, 1);
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 8'hAA, 0);
         checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL rw_count[%0d]: got %0d expected 16", i, bus.count); end
         checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rw_ovf[%0d]: got %b expected 0", i, bus.overflow); end
      end
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rw_drained: got %b expected 1", bus.empty); end
   endtask

   task automatic test_empty_rw();
      step(1, 1, 8'h5C, 0);
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL erw_count: got %0d expected 1", bus.count); end
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL erw_unf: got %b expected 1", bus.underflow); end
      step(0, 1, 8'h00, 0);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL erw_count0: got %0d expected 0", bus.count); end
      step(0, 0, 8'h00, 1);
      checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL erw_clear: got %b expected 0", bus.underflow); end
   endtask

   task automatic test_clear_collision();
      step(0, 1, 8'h00, 0);
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL coll_set: got %b expected 1", bus.underflow); end
      step(0, 1, 8'h00, 1);
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL coll_keep: got %b expected 1", bus.underflow); end
      step(0, 0, 8'h00, 1);
      checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", bus.underflow); end
   endtask

   task automatic test_async_reset();
      step(0, 1, 8'h00, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 8'h70 + 8'(i), 0);
      checks++; if (bus.count !== 5'd7) begin errors++; $display("FAIL ar_count7: got %0d expected 7", bus.count); end
      #2;
      reset = 1'b1;
      #1;
      model_q.delete();
      test_reset();
      #3;
      reset = 1'b0;
      step(1, 0, 8'h3C, 0);
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL ar_count1: got %0d expected 1", bus.count); end
      step(0, 1, 8'h00, 0);
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL ar_count0: got %0d expected 0", bus.count); end
   endtask

   initial begin
      reset              = 1'b1;
      bus.write_to_fifo  = 1'b0;
      bus.read_from_fifo = 1'b0;
      bus.write_data_in  = 8'h00;
      bus.clear_errors   = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      test_basic();
      test_fill_overflow();
      test_full_rw();
      test_empty_rw();
      test_clear_collision();
      test_async_reset();
      checks++; if (model_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", model_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
